dmem_arbiter: RTL and testbench

- Shares the single data-memory port and the GPIO register window between two requesters: port 0 is the CPU load/store path, port 1 is the program loader/debug path.
- Decodes each request into DMEM, GPIO or error, and issues at most one access per cycle.
- Returns a registered response one cycle after grant.
- Arbitration is round-robin, with a bounded bus lock for loader bursts.

---
 rtl/dmem_map_pkg.sv | 20 ++
 rtl/dmem_arbiter_if.sv | 26 ++
 rtl/dmem_arbiter_addr_decode.sv | 45 ++++
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_map_pkg.sv
// Shared data-memory map: window constants, decode regions and arbiter FSM states.
// Used by the arbiter, data memory, GPIO block and program loader.
package dmem_map_pkg;

  localparam logic [31:0] DMEM_START = 32'h0200_0000;
  localparam logic [31:0] GPIO_START = 32'h0200_0800;
  localparam logic [31:0] GPIO_END   = 32'h0200_081C;

  typedef enum logic [1:0] {
    DEC_DMEM,
    DEC_GPIO,
    DEC_ERR
  } dec_region_t;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request/grant plus a one-cycle response.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/dmem_arbiter_addr_decode.sv
// Combinational byte-address decode into DMEM word index, GPIO register index or error.
module addr_decode
  import dmem_map_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 512
) (
  input  logic [ADDR_WIDTH-1:0]       addr,
  output dec_region_t                 region,
  output logic [$clog2(MEM_SIZE)-1:0] mem_idx,
  output logic [2:0]                  gpio_sel,
  output logic                        err
);

  localparam int IDX_W = $clog2(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] DMEM_LO = ADDR_WIDTH'(DMEM_START);
  localparam logic [ADDR_WIDTH-1:0] DMEM_HI = ADDR_WIDTH'(DMEM_START + 32'(MEM_SIZE * 4));
  localparam logic [ADDR_WIDTH-1:0] GPIO_LO = ADDR_WIDTH'(GPIO_START);
  localparam logic [ADDR_WIDTH-1:0] GPIO_HI = ADDR_WIDTH'(GPIO_END);

  logic in_dmem;
  logic in_gpio;
  logic aligned;

  assign in_dmem = (addr >= DMEM_LO) && (addr < DMEM_HI);
  assign in_gpio = (addr >= GPIO_LO) && (addr <= GPIO_HI);
  assign aligned = (addr[1:0] == 2'b00);

  // GPIO is checked first so it wins should the windows ever overlap.
  always_comb begin
    region = DEC_ERR;
    if (aligned) begin
      if (in_gpio) begin
        region = DEC_GPIO;
      end else if (in_dmem) begin
        region = DEC_DMEM;
      end
    end
  end

  assign mem_idx  = addr[IDX_W+1:2];
  assign gpio_sel = addr[4:2];
  assign err      = (region == DEC_ERR);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the DMEM port and GPIO window between the CPU (port 0)
// and the loader/debug path (port 1), with a bounded bus lock for loader bursts.
module dmem_arbiter
  import dmem_map_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 512,
  parameter int LOCK_MAX   = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  dmem_arbiter_if.slave               m0,
  dmem_arbiter_if.slave               m1,
  input  logic                        m1_lock,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  output logic                        gpio_en,
  output logic                        gpio_we,
  output logic [2:0]                  gpio_sel,
  output logic [DATA_WIDTH-1:0]       gpio_wdata,
  input  logic [DATA_WIDTH-1:0]       gpio_rdata,
  output logic                        lock_timeout
);

  localparam int IDX_W = $clog2(MEM_SIZE);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t       state;
  logic [CNT_W-1:0] lock_cnt;
  logic             last_gnt;
  logic             timeout_q;

  logic                  gnt0;
  logic                  gnt1;
  logic                  any_gnt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_wdata;

  dec_region_t      region;
  logic [IDX_W-1:0] dec_idx;
  logic [2:0]       dec_sel;
  logic             dec_err;

  logic                  rsp_valid;
  logic                  rsp_port;
  logic                  rsp_we;
  logic                  rsp_err;
  logic                  rsp_gpio;
  logic                  rsp_live;
  logic [DATA_WIDTH-1:0] rsp_data;

  // Port 0 wins a tie when port 1 was granted last or right after a forced lock release.
  assign gnt0    = !rst && m0.req && (state == ST_IDLE) && (!m1.req || timeout_q || last_gnt);
  assign gnt1    = !rst && m1.req && !gnt0;
  assign any_gnt = gnt0 || gnt1;

  assign sel_addr  = gnt1 ? m1.addr  : m0.addr;
  assign sel_we    = gnt1 ? m1.we    : m0.we;
  assign sel_wdata = gnt1 ? m1.wdata : m0.wdata;

  addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_SIZE   (MEM_SIZE)
  ) u_decode (
    .addr     (sel_addr),
    .region   (region),
    .mem_idx  (dec_idx),
    .gpio_sel (dec_sel),
    .err      (dec_err)
  );

  assign mem_en     = any_gnt && (region == DEC_DMEM);
  assign mem_we     = mem_en && sel_we;
  assign mem_addr   = mem_en ? dec_idx : '0;
  assign mem_wdata  = mem_we ? sel_wdata : '0;
  assign gpio_en    = any_gnt && (region == DEC_GPIO);
  assign gpio_we    = gpio_en && sel_we;
  assign gpio_sel   = gpio_en ? dec_sel : '0;
  assign gpio_wdata = gpio_we ? sel_wdata : '0;

  // A voluntary release takes precedence over the timeout so lock_timeout only flags forced releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lock_cnt  <= '0;
      last_gnt  <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (any_gnt) begin
        last_gnt <= gnt1;
      end
      case (state)
        ST_IDLE: begin
          if (gnt1 && m1_lock) begin
            state    <= ST_LOCKED;
            lock_cnt <= '0;
          end
        end
        ST_LOCKED: begin
          lock_cnt <= lock_cnt + 1'b1;
          if (!m1_lock && (gnt1 || !m1.req)) begin
            state <= ST_IDLE;
          end else if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
            state     <= ST_IDLE;
            timeout_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_port  <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_gpio  <= 1'b0;
    end else begin
      rsp_valid <= any_gnt;
      rsp_port  <= gnt1;
      rsp_we    <= sel_we;
      rsp_err   <= dec_err;
      rsp_gpio  <= (region == DEC_GPIO);
    end
  end

  // Read data arrives from the memory/GPIO the cycle after the strobe, steered by the registered decode.
  assign rsp_live = rsp_valid && !rst;
  assign rsp_data = (rsp_live && !rsp_we && !rsp_err) ? (rsp_gpio ? gpio_rdata : mem_rdata) : '0;

  assign m0.gnt    = gnt0;
  assign m0.rvalid = rsp_live && !rsp_port;
  assign m0.err    = rsp_live && !rsp_port && rsp_err;
  assign m0.rdata  = !rsp_port ? rsp_data : '0;

  assign m1.gnt    = gnt1;
  assign m1.rvalid = rsp_live && rsp_port;
  assign m1.err    = rsp_live && rsp_port && rsp_err;
  assign m1.rdata  = rsp_port ? rsp_data : '0;

  assign lock_timeout = timeout_q && !rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: decode, round-robin, lock/timeout and reset behaviour,
// with a small DMEM/GPIO model answering the strobes.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MS = 512;
  localparam int LM = 4;

  localparam int R_DMEM = 0;
  localparam int R_GPIO = 1;
  localparam int R_ERR  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m1_lock;
  logic          mem_en, mem_we, gpio_en, gpio_we, lock_timeout;
  logic [8:0]    mem_addr;
  logic [2:0]    gpio_sel;
  logic [DW-1:0] mem_wdata, mem_rdata, gpio_wdata, gpio_rdata;

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_bus ();
  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_bus ();

  dmem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_SIZE   (MS),
    .LOCK_MAX   (LM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .m0           (m0_bus),
    .m1           (m1_bus),
    .m1_lock      (m1_lock),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .gpio_en      (gpio_en),
    .gpio_we      (gpio_we),
    .gpio_sel     (gpio_sel),
    .gpio_wdata   (gpio_wdata),
    .gpio_rdata   (gpio_rdata),
    .lock_timeout (lock_timeout)
  );

  always #5 clk = ~clk;

  // Memory and GPIO models: synchronous write, read data valid the cycle after the strobe.
  logic [31:0] mem_model  [MS];
  logic [31:0] gpio_model [8];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MS; i++) mem_model[i] <= (i == 1) ? 32'hDEAD_BEEF : 32'h0;
      for (int j = 0; j < 8; j++) gpio_model[j] <= 32'h0;
      mem_rdata  <= '0;
      gpio_rdata <= '0;
    end else begin
      if (mem_en) begin
        if (mem_we) mem_model[mem_addr] <= mem_wdata;
        mem_rdata <= mem_model[mem_addr];
      end
      if (gpio_en) begin
        if (gpio_we) gpio_model[gpio_sel] <= gpio_wdata;
        gpio_rdata <= gpio_model[gpio_sel];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit port, input bit req, input bit we, input bit lock,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      m1_bus.req   = req;
      m1_bus.we    = we;
      m1_bus.addr  = addr;
      m1_bus.wdata = wdata;
      m1_lock      = lock;
    end else begin
      m0_bus.req   = req;
      m0_bus.we    = we;
      m0_bus.addr  = addr;
      m0_bus.wdata = wdata;
    end
  endtask

  task automatic idleAll();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One isolated access: checks grant and strobes in the grant cycle, then the response.
  task automatic runAccess(input string tag, input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int region, input int idx,
                           input logic [31:0] exp_rdata);
    applyStimulus(port, 1'b1, we, 1'b0, addr, wdata);
    @(negedge clk);
    checkOutput({tag, "_gnt"}, port ? m1_bus.gnt : m0_bus.gnt, 32'd1);
    checkOutput({tag, "_mem_en"}, mem_en, (region == R_DMEM) ? 32'd1 : 32'd0);
    checkOutput({tag, "_gpio_en"}, gpio_en, (region == R_GPIO) ? 32'd1 : 32'd0);
    if (region == R_DMEM) begin
      checkOutput({tag, "_mem_addr"}, mem_addr, idx);
      checkOutput({tag, "_mem_we"}, mem_we, we);
      if (we) checkOutput({tag, "_mem_wdata"}, mem_wdata, wdata);
    end
    if (region == R_GPIO) begin
      checkOutput({tag, "_gpio_sel"}, gpio_sel, idx);
      checkOutput({tag, "_gpio_we"}, gpio_we, we);
      if (we) checkOutput({tag, "_gpio_wdata"}, gpio_wdata, wdata);
    end
    nextCycle();
    idleAll();
    @(negedge clk);
    checkOutput({tag, "_rvalid"}, port ? m1_bus.rvalid : m0_bus.rvalid, 32'd1);
    checkOutput({tag, "_err"}, port ? m1_bus.err : m0_bus.err, (region == R_ERR) ? 32'd1 : 32'd0);
    checkOutput({tag, "_rdata"}, port ? m1_bus.rdata : m0_bus.rdata, exp_rdata);
    nextCycle();
  endtask

  initial begin
    // Both ports request while reset is held: nothing may be granted or strobed.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0200_0008, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0200_000C, 32'h0);
    @(negedge clk);
    checkOutput("rst_m0_gnt", m0_bus.gnt, 32'd0);
    checkOutput("rst_m1_gnt", m1_bus.gnt, 32'd0);
    checkOutput("rst_mem_en", mem_en, 32'd0);
    checkOutput("rst_gpio_en", gpio_en, 32'd0);
    checkOutput("rst_timeout", lock_timeout, 32'd0);
    checkOutput("rst_m0_rvalid", m0_bus.rvalid, 32'd0);
    nextCycle();
    rst = 1'b0;

    // Continuous contention after reset alternates starting with port 0.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("cont%0d_m0_gnt", i), m0_bus.gnt, (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("cont%0d_m1_gnt", i), m1_bus.gnt, (i % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("cont%0d_m0_rvalid", i), m0_bus.rvalid,
                  (i > 0 && (i % 2 == 1)) ? 32'd1 : 32'd0);
      checkOutput($sformatf("cont%0d_m1_rvalid", i), m1_bus.rvalid,
                  (i > 0 && (i % 2 == 0)) ? 32'd1 : 32'd0);
      nextCycle();
    end
    idleAll();
    nextCycle();

    runAccess("rd_word1",  1'b0, 1'b0, 32'h0200_0004, 32'h0,          R_DMEM, 1,   32'hDEAD_BEEF);
    runAccess("wr_misal",  1'b1, 1'b1, 32'h0200_0802, 32'h1111_2222,  R_ERR,  0,   32'h0);
    runAccess("wr_unmap",  1'b0, 1'b1, 32'h0300_0000, 32'h3333_4444,  R_ERR,  0,   32'h0);
    runAccess("wr_gpio4",  1'b0, 1'b1, 32'h0200_0810, 32'hA5A5_0001,  R_GPIO, 4,   32'h0);
    runAccess("rd_gpio4",  1'b1, 1'b0, 32'h0200_0810, 32'h0,          R_GPIO, 4,   32'hA5A5_0001);
    runAccess("wr_dlast",  1'b1, 1'b1, 32'h0200_07FC, 32'h1234_5678,  R_DMEM, 511, 32'h0);
    runAccess("rd_dlast",  1'b0, 1'b0, 32'h0200_07FC, 32'h0,          R_DMEM, 511, 32'h1234_5678);
    runAccess("rd_gpio0",  1'b0, 1'b0, 32'h0200_0800, 32'h0,          R_GPIO, 0,   32'h0);
    runAccess("rd_gpend",  1'b1, 1'b0, 32'h0200_0820, 32'h0,          R_ERR,  0,   32'h0);
    runAccess("rd_below",  1'b0, 1'b0, 32'h01FF_FFFC, 32'h0,          R_ERR,  0,   32'h0);

    // Locked burst of three writes from port 1 blocks port 0 until the unlocked third write.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0200_0020, 32'h1);
    @(negedge clk);
    checkOutput("lock_a_m1_gnt", m1_bus.gnt, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0200_0004, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0200_0024, 32'h2);
    @(negedge clk);
    checkOutput("lock_b_m0_gnt", m0_bus.gnt, 32'd0);
    checkOutput("lock_b_m1_gnt", m1_bus.gnt, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0200_0028, 32'h3);
    @(negedge clk);
    checkOutput("lock_c_m0_gnt", m0_bus.gnt, 32'd0);
    checkOutput("lock_c_m1_gnt", m1_bus.gnt, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("lock_d_m0_gnt", m0_bus.gnt, 32'd1);
    nextCycle();
    idleAll();
    nextCycle();

    // Lock held forever: forced release after LM locked cycles, port 0 served in the pulse cycle.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0200_0030, 32'h5);
    @(negedge clk);
    checkOutput("tmo_enter_m1_gnt", m1_bus.gnt, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0200_0004, 32'h0);
    for (int k = 0; k < LM; k++) begin
      @(negedge clk);
      checkOutput($sformatf("tmo_locked%0d_m0_gnt", k), m0_bus.gnt, 32'd0);
      checkOutput($sformatf("tmo_locked%0d_m1_gnt", k), m1_bus.gnt, 32'd1);
      checkOutput($sformatf("tmo_locked%0d_pulse", k), lock_timeout, 32'd0);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("tmo_pulse", lock_timeout, 32'd1);
    checkOutput("tmo_m0_gnt", m0_bus.gnt, 32'd1);
    checkOutput("tmo_m1_gnt", m1_bus.gnt, 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("tmo_after_pulse", lock_timeout, 32'd0);
    checkOutput("tmo_after_m0_gnt", m0_bus.gnt, 32'd0);
    checkOutput("tmo_after_m1_gnt", m1_bus.gnt, 32'd1);
    nextCycle();
    idleAll();
    nextCycle();
    nextCycle();

    // Reset right after a read grant drops the response; first tie afterwards goes to port 0.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0200_0004, 32'h0);
    @(negedge clk);
    checkOutput("rr_m0_gnt", m0_bus.gnt, 32'd1);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0200_0008, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0200_000C, 32'h0);
    @(negedge clk);
    checkOutput("rr_m0_rvalid", m0_bus.rvalid, 32'd0);
    checkOutput("rr_m0_rdata", m0_bus.rdata, 32'd0);
    checkOutput("rr_m0_gnt_in_rst", m0_bus.gnt, 32'd0);
    checkOutput("rr_m1_gnt_in_rst", m1_bus.gnt, 32'd0);
    checkOutput("rr_mem_en_in_rst", mem_en, 32'd0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rr_tie_m0_gnt", m0_bus.gnt, 32'd1);
    checkOutput("rr_tie_m1_gnt", m1_bus.gnt, 32'd0);
    checkOutput("rr_no_m0_rvalid", m0_bus.rvalid, 32'd0);
    checkOutput("rr_no_m1_rvalid", m1_bus.rvalid, 32'd0);
    nextCycle();
    idleAll();
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
